uart_dc_deframer: RTL and testbench
===================================

UART_DC_DEFRAMER -- requirements
Module: uart_dc_deframer

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 32, giving the maximum payload words per frame (legal range 1..255).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, giving the frame start marker.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000, giving the inter-byte idle limit in clocks; counter width SHALL be $clog2(TIMEOUT_CYCLES+1).
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-low (low = reset).
REQ-006 SHALL have port i_rxq_data, input, 8 bits: head byte of the UART RX FIFO, valid when i_rxq_empty=0 (first-word fall-through).
REQ-007 SHALL have port i_rxq_empty, input, 1 bit: RX FIFO empty.
REQ-008 SHALL have port o_rxq_deq, output, 1 bit: pops the head byte, which is consumed in the same cycle.
REQ-009 SHALL have port o_word_data, output, 32 bits: the assembled payload word.
REQ-010 SHALL have port o_word_valid, output, 1 bit: o_word_data is valid.
REQ-011 SHALL have port i_word_ready, input, 1 bit: the downstream accepts the word.
REQ-012 SHALL have port o_frame_start, output, 1 bit: one-cycle pulse marking that the header and count have been accepted.
REQ-013 SHALL have port o_frame_type, output, 3 bits: header[7:5], held from o_frame_start until the next frame start.
REQ-014 SHALL have port o_frame_channel, output, 5 bits: header[4:0], held from o_frame_start until the next frame start.
REQ-015 SHALL have port o_frame_done, output, 1 bit: one-cycle pulse marking that the frame passed its checksum.
REQ-016 SHALL have port o_frame_err, output, 1 bit: one-cycle pulse marking that the frame was aborted.
REQ-017 SHALL have port o_err_code, output, 2 bits: 0 = none, 1 = bad count, 2 = timeout, 3 = checksum; held until the next o_frame_start, which clears it to 0.
REQ-018 SHALL have port o_busy, output, 1 bit: high when the state is not HUNT.

Function
REQ-019 The frame format SHALL be: SYNC_BYTE, header, count N, 4N payload bytes (each word MSB first), then one checksum byte.
REQ-020 The checksum SHALL be the XOR of every byte from the header through the last payload byte.
REQ-021 The state machine SHALL have the states HUNT, HDR, CNT, PAYLOAD and CSUM.
REQ-022 In HUNT, the block SHALL pop every available byte; a byte equal to SYNC_BYTE SHALL move the state to HDR, and any other byte SHALL be discarded.
REQ-023 In HDR, the block SHALL pop one byte, latch it as the header, seed the checksum with it, and move to CNT.
REQ-024 In CNT, a popped byte N with N=0 or N>MAX_WORDS SHALL give o_frame_err, o_err_code=1 and a return to HUNT.
REQ-025 In CNT, a popped byte N with 1<=N<=MAX_WORDS SHALL update o_frame_type, o_frame_channel and o_err_code=0, pulse o_frame_start in the following cycle, and move to PAYLOAD.
REQ-026 In PAYLOAD, bytes SHALL shift into a word accumulator and be XORed into the checksum.
REQ-027 A fourth byte SHALL be popped only if the output register is empty or is being drained that cycle (o_word_valid & i_word_ready); the completed word SHALL appear on o_word_data with o_word_valid=1 in the next cycle.
REQ-028 Bytes 1 to 3 of a word SHALL be popped regardless of the output register state.
REQ-029 o_word_valid SHALL stay high and o_word_data SHALL stay stable until i_word_ready=1; a word SHALL transfer on the cycle where o_word_valid & i_word_ready.
REQ-030 Back-to-back words SHALL be sustainable with no bubble cycle caused by the register when the downstream holds i_word_ready=1.
REQ-031 After the 4N-th payload byte the state SHALL move to CSUM.
REQ-032 In CSUM, the checksum byte SHALL NOT be popped until o_word_valid=0, i.e. the last word has been delivered.
REQ-033 On a checksum match the block SHALL pulse o_frame_done in the next cycle and return to HUNT.
REQ-034 On a checksum mismatch the block SHALL pulse o_frame_err with o_err_code=3 in the next cycle and return to HUNT.
REQ-035 Timeout: outside HUNT, the idle counter SHALL increment only in cycles with i_rxq_empty=1, and SHALL clear when a byte is popped or i_rxq_empty=0.
REQ-036 When the idle counter reaches TIMEOUT_CYCLES, the block SHALL pulse o_frame_err with o_err_code=2, drop the partial word accumulator, and return to HUNT.
REQ-037 A word already held in the output register at a timeout SHALL still be delivered.
REQ-038 On o_frame_err, the downstream SHALL discard every word delivered since the last o_frame_start; the block SHALL NOT retract any word already delivered.
REQ-039 A SYNC_BYTE value appearing inside HDR, CNT, PAYLOAD or CSUM SHALL be treated as data.
REQ-040 o_frame_done and o_frame_err SHALL never be high in the same cycle.
REQ-041 o_rxq_deq SHALL never be high while i_rxq_empty=1.

Reset
REQ-042 While i_rst=0, the state SHALL be HUNT and the accumulator, checksum, byte and word counters, and idle counter SHALL be 0.
REQ-043 While i_rst=0, every output SHALL be 0: o_rxq_deq, o_word_valid, o_word_data, o_frame_start, o_frame_done, o_frame_err, o_err_code, o_frame_type, o_frame_channel and o_busy.
REQ-044 A reset asserted mid-frame SHALL abort the frame with no o_frame_err pulse and SHALL drop any pending output word.
REQ-045 Reset release SHALL be synchronised to i_clk before it affects the state.

Verification
REQ-046 Bytes A5 17 02 11 22 33 44 55 66 77 88 with checksum 17^02^11^22^33^44^55^66^77^88, i_word_ready=1 -> o_frame_start once; type=0; channel=23; words 0x11223344 and 0x55667788; o_frame_done once; o_err_code=0.
REQ-047 Same frame with checksum byte XORed with 0x01 -> both words delivered, then o_frame_err and o_err_code=3, no o_frame_done.
REQ-048 Bytes A5 01 00, then A5 01 21 with MAX_WORDS=32 -> two o_frame_err pulses with o_err_code=1 and no o_frame_start.
REQ-049 Frame with N=2 and i_word_ready=0 for 50 cycles after the first word -> o_word_data holds 0x11223344; bytes 5 to 7 popped, the 8th byte not popped; no timeout; the frame then completes normally.
REQ-050 TIMEOUT_CYCLES=10, bytes A5 05 01 AA then FIFO empty -> o_frame_err with o_err_code=2 exactly 10 empty cycles after the last pop; o_busy=0 afterwards.
REQ-051 Leading garbage bytes 00 FF 5A, then a valid frame -> the garbage is discarded and the frame is received correctly; i_rst pulsed low during PAYLOAD -> all outputs read 0 and the next frame decodes correctly.

Source files
------------

// File: rtl/uart_dc_deframer.sv
// uart_dc_deframer
//   Pulls bytes from a first-word-fall-through UART RX FIFO, hunts for the
//   sync marker and deframes  SYNC | header | N | 4N payload bytes | checksum.
//   Payload bytes are packed MSB-first into 32-bit words and handed out through
//   a single valid/ready output register. The checksum is the XOR of the header,
//   the count and every payload byte. The frame is aborted when any of these
//   happens: the count is bad, the checksum fails, or the input sits idle for
//   TIMEOUT_CYCLES clocks mid-frame.
//
// Ports
//   i_clk           clock, rising edge
//   i_rst           asynchronous active-low reset; release is synchronised
//   i_rxq_data      FIFO head byte (valid when i_rxq_empty = 0)
//   i_rxq_empty     FIFO empty flag
//   o_rxq_deq       pop the FIFO head this cycle
//   o_word_data     assembled payload word
//   o_word_valid    o_word_data holds a word for the downstream
//   i_word_ready    downstream accepts the word
//   o_frame_start   pulse: header and count accepted
//   o_frame_type    header[7:5] of the current frame
//   o_frame_channel header[4:0] of the current frame
//   o_frame_done    pulse: frame passed its checksum
//   o_frame_err     pulse: frame aborted
//   o_err_code      0 none, 1 bad count, 2 timeout, 3 checksum
//   o_busy          deframer is inside a frame
module uart_dc_deframer #(
  parameter int         MAX_WORDS      = 32,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rxq_data,
  input  logic        i_rxq_empty,
  output logic        o_rxq_deq,
  output logic [31:0] o_word_data,
  output logic        o_word_valid,
  input  logic        i_word_ready,
  output logic        o_frame_start,
  output logic [2:0]  o_frame_type,
  output logic [4:0]  o_frame_channel,
  output logic        o_frame_done,
  output logic        o_frame_err,
  output logic [1:0]  o_err_code,
  output logic        o_busy
);

  localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  // The timeout fires on the empty cycle that would take the count to TIMEOUT_CYCLES.
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]        MAX_N     = 8'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_HUNT, S_HDR, S_CNT, S_PAYLOAD, S_CSUM
  } state_e;

  // Reset assertion is immediate; release is delayed two clocks so every
  // flop leaves reset on the same edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  state_e            state_q,      state_d;
  logic [7:0]        hdr_q,        hdr_d;
  logic [7:0]        csum_q,       csum_d;
  logic [23:0]       acc_q,        acc_d;
  logic [1:0]        byte_cnt_q,   byte_cnt_d;
  logic [7:0]        words_left_q, words_left_d;
  logic [IDLE_W-1:0] idle_q,       idle_d;
  logic [31:0]       word_data_q,  word_data_d;
  logic              word_valid_q, word_valid_d;
  logic              start_q,      start_d;
  logic              done_q,       done_d;
  logic              err_q,        err_d;
  logic [1:0]        err_code_q,   err_code_d;
  logic [2:0]        type_q,       type_d;
  logic [4:0]        chan_q,       chan_d;
  logic              deq;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_HUNT;
      hdr_q        <= '0;
      csum_q       <= '0;
      acc_q        <= '0;
      byte_cnt_q   <= '0;
      words_left_q <= '0;
      idle_q       <= '0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= '0;
      type_q       <= '0;
      chan_q       <= '0;
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      csum_q       <= csum_d;
      acc_q        <= acc_d;
      byte_cnt_q   <= byte_cnt_d;
      words_left_q <= words_left_d;
      idle_q       <= idle_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      start_q      <= start_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      type_q       <= type_d;
      chan_q       <= chan_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    csum_d       = csum_q;
    acc_d        = acc_q;
    byte_cnt_d   = byte_cnt_q;
    words_left_d = words_left_q;
    idle_d       = idle_q;
    word_data_d  = word_data_q;
    word_valid_d = word_valid_q;
    start_d      = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    type_d       = type_q;
    chan_d       = chan_q;
    deq          = 1'b0;

    // The downstream takes the held word; a new word loaded below overrides this.
    if (word_valid_q && i_word_ready) word_valid_d = 1'b0;

    unique case (state_q)
      S_HUNT: begin
        deq = !i_rxq_empty;
        if (deq && (i_rxq_data == SYNC_BYTE)) state_d = S_HDR;
      end
      S_HDR: begin
        deq = !i_rxq_empty;
        if (deq) begin
          hdr_d   = i_rxq_data;
          csum_d  = i_rxq_data;
          state_d = S_CNT;
        end
      end
      S_CNT: begin
        deq = !i_rxq_empty;
        if (deq) begin
          if ((i_rxq_data == 8'd0) || (i_rxq_data > MAX_N)) begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
            state_d    = S_HUNT;
          end else begin
            start_d      = 1'b1;
            type_d       = hdr_q[7:5];
            chan_d       = hdr_q[4:0];
            err_code_d   = 2'd0;
            csum_d       = csum_q ^ i_rxq_data;
            words_left_d = i_rxq_data;
            byte_cnt_d   = 2'd0;
            acc_d        = '0;
            state_d      = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        // The last byte of a word needs room in the output register; the
        // other three only go into the accumulator and never stall.
        deq = !i_rxq_empty &&
              ((byte_cnt_q != 2'd3) || !word_valid_q || i_word_ready);
        if (deq) begin
          csum_d = csum_q ^ i_rxq_data;
          if (byte_cnt_q == 2'd3) begin
            word_data_d  = {acc_q, i_rxq_data};
            word_valid_d = 1'b1;
            acc_d        = '0;
            byte_cnt_d   = 2'd0;
            words_left_d = words_left_q - 8'd1;
            if (words_left_q == 8'd1) state_d = S_CSUM;
          end else begin
            acc_d      = {acc_q[15:0], i_rxq_data};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      S_CSUM: begin
        // Hold the checksum byte until the last word has left, so done/err
        // never precedes the final word.
        deq = !i_rxq_empty && !word_valid_q;
        if (deq) begin
          if (i_rxq_data == csum_q) begin
            done_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = 2'd3;
          end
          state_d = S_HUNT;
        end
      end
      default: state_d = S_HUNT;
    endcase

    // Idle watchdog: only empty cycles inside a frame count. A held output
    // word is left alone so it is still delivered.
    if (state_q == S_HUNT || !i_rxq_empty) begin
      idle_d = '0;
    end else if (idle_q == IDLE_LAST) begin
      idle_d     = '0;
      err_d      = 1'b1;
      err_code_d = 2'd2;
      acc_d      = '0;
      byte_cnt_d = 2'd0;
      state_d    = S_HUNT;
    end else begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  assign o_rxq_deq       = deq & rst_n;
  assign o_word_data     = word_data_q;
  assign o_word_valid    = word_valid_q;
  assign o_frame_start   = start_q;
  assign o_frame_type    = type_q;
  assign o_frame_channel = chan_q;
  assign o_frame_done    = done_q;
  assign o_frame_err     = err_q;
  assign o_err_code      = err_code_q;
  assign o_busy          = (state_q != S_HUNT);

endmodule

// File: tb/tb_uart_dc_deframer.sv
// Directed testbench for uart_dc_deframer: a queue models the RX FIFO and
// per-cycle monitors count pulses and capture delivered words.
module tb_uart_dc_deframer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rxq_data;
  logic        rxq_empty;
  logic        rxq_deq;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        frame_start;
  logic [2:0]  frame_type;
  logic [4:0]  frame_channel;
  logic        frame_done;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;

  always #5 clk = ~clk;

  uart_dc_deframer #(
    .MAX_WORDS(32), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(10)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rxq_data(rxq_data), .i_rxq_empty(rxq_empty), .o_rxq_deq(rxq_deq),
    .o_word_data(word_data), .o_word_valid(word_valid), .i_word_ready(word_ready),
    .o_frame_start(frame_start), .o_frame_type(frame_type),
    .o_frame_channel(frame_channel), .o_frame_done(frame_done),
    .o_frame_err(frame_err), .o_err_code(err_code), .o_busy(busy)
  );

  logic [7:0]  fifo[$];
  logic [7:0]  pl[$];
  int          n_checks = 0, n_fail = 0;
  int          cyc = 0, n_start, n_done, n_err, n_words, last_pop, first_err_cyc;
  int          viol_deq = 0, viol_both = 0;
  logic [31:0] words[64];
  int          word_cyc[64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sync_pins();
    rxq_empty = (fifo.size() == 0);
    rxq_data  = rxq_empty ? 8'h00 : fifo[0];
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    sync_pins();
  endtask

  task automatic clear_mon();
    n_start = 0; n_done = 0; n_err = 0; n_words = 0; first_err_cyc = -1;
    for (int i = 0; i < 64; i++) begin words[i] = '0; word_cyc[i] = 0; end
  endtask

  // One clock: observe at the falling edge, pop the model FIFO after the rising edge.
  task automatic step();
    logic popped;
    @(negedge clk);
    popped = rxq_deq;
    if (rxq_deq && rxq_empty) viol_deq++;
    if (frame_done && frame_err) viol_both++;
    if (frame_start) n_start++;
    if (frame_done) n_done++;
    if (frame_err) begin
      n_err++;
      if (first_err_cyc < 0) first_err_cyc = cyc;
    end
    if (word_valid && word_ready) begin
      if (n_words < 64) begin words[n_words] = word_data; word_cyc[n_words] = cyc; end
      n_words++;
    end
    if (popped) last_pop = cyc;
    @(posedge clk);
    #1;
    if (popped && fifo.size() > 0) fifo.delete(0);
    sync_pins();
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Pushes SYNC, header, count, payload pl[] and checksum XOR mask.
  task automatic push_frame(input logic [7:0] hdr, input logic [7:0] n, input logic [7:0] mask);
    logic [7:0] cs;
    cs = hdr ^ n;
    push(8'hA5); push(hdr); push(n);
    foreach (pl[i]) begin push(pl[i]); cs = cs ^ pl[i]; end
    push(cs ^ mask);
  endtask

  task automatic load_pl_a();
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  endtask

  initial begin
    logic [31:0] exp_last;
    rst = 1'b0; word_ready = 1'b1;
    sync_pins();
    clear_mon();

    // Reset: outputs low even with a byte waiting in the FIFO
    push(8'hA5);
    run(3);
    check("rst_deq", rxq_deq, 0);
    check("rst_valid", word_valid, 0);
    check("rst_data", word_data, 0);
    check("rst_start", frame_start, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", frame_err, 0);
    check("rst_code", err_code, 0);
    check("rst_type_chan", {frame_type, frame_channel}, 0);
    check("rst_busy", busy, 0);
    check("rst_no_pop", fifo.size(), 1);
    fifo.delete(); sync_pins();
    rst = 1'b1;
    run(4);

    // Good frame, two words back to back
    clear_mon(); load_pl_a();
    push_frame(8'h17, 8'd2, 8'h00);
    run(30);
    check("a_start", n_start, 1);
    check("a_type", frame_type, 0);
    check("a_chan", frame_channel, 23);
    check("a_nwords", n_words, 2);
    check("a_w0", words[0], 32'h11223344);
    check("a_w1", words[1], 32'h55667788);
    check("a_gap", word_cyc[1] - word_cyc[0], 4);
    check("a_done", n_done, 1);
    check("a_err", n_err, 0);
    check("a_code", err_code, 0);
    check("a_busy", busy, 0);

    // Corrupted checksum
    clear_mon(); load_pl_a();
    push_frame(8'h17, 8'd2, 8'h01);
    run(30);
    check("b_nwords", n_words, 2);
    check("b_w1", words[1], 32'h55667788);
    check("b_err", n_err, 1);
    check("b_done", n_done, 0);
    check("b_code", err_code, 3);

    // Bad counts 0 and MAX_WORDS+1
    clear_mon();
    push(8'hA5); push(8'h01); push(8'h00);
    push(8'hA5); push(8'h01); push(8'h21);
    run(15);
    check("c_err", n_err, 2);
    check("c_start", n_start, 0);
    check("c_code", err_code, 1);

    // Count at MAX_WORDS is accepted
    clear_mon();
    pl = {};
    for (int i = 0; i < 128; i++) pl.push_back(8'((i * 37 + 5) & 8'hFF));
    exp_last = {pl[124], pl[125], pl[126], pl[127]};
    push_frame(8'hE3, 8'd32, 8'h00);
    run(160);
    check("m_nwords", n_words, 32);
    check("m_last", words[31], exp_last);
    check("m_done", n_done, 1);
    check("m_type_chan", {frame_type, frame_channel}, {3'd7, 5'd3});

    // Backpressure: first word held, 8th payload byte stays in the FIFO
    clear_mon(); load_pl_a(); word_ready = 1'b0;
    push_frame(8'h17, 8'd2, 8'h00);
    run(50);
    check("d_valid", word_valid, 1);
    check("d_data", word_data, 32'h11223344);
    check("d_fifo_left", fifo.size(), 2);
    check("d_no_err", n_err, 0);
    check("d_busy", busy, 1);
    word_ready = 1'b1;
    run(20);
    check("d_nwords", n_words, 2);
    check("d_w0", words[0], 32'h11223344);
    check("d_w1", words[1], 32'h55667788);
    check("d_done", n_done, 1);

    // Idle timeout in PAYLOAD
    clear_mon();
    push(8'hA5); push(8'h05); push(8'h01); push(8'hAA);
    run(25);
    check("e_err", n_err, 1);
    check("e_latency", first_err_cyc - last_pop, 11);
    check("e_code", err_code, 2);
    check("e_busy", busy, 0);
    check("e_valid", word_valid, 0);

    // Timeout with a word still held: the word survives
    clear_mon(); word_ready = 1'b0;
    push(8'hA5); push(8'h05); push(8'h01);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    run(25);
    check("f_err", n_err, 1);
    check("f_code", err_code, 2);
    check("f_valid", word_valid, 1);
    check("f_data", word_data, 32'h11223344);
    word_ready = 1'b1;
    run(3);
    check("f_delivered", n_words, 1);

    // Leading garbage, then a valid frame
    clear_mon(); load_pl_a();
    push(8'h00); push(8'hFF); push(8'h5A);
    push_frame(8'h17, 8'd2, 8'h00);
    run(30);
    check("g_nwords", n_words, 2);
    check("g_w0", words[0], 32'h11223344);
    check("g_w1", words[1], 32'h55667788);
    check("g_done", n_done, 1);
    check("g_err", n_err, 0);

    // Reset during PAYLOAD, then a fresh frame
    clear_mon(); load_pl_a();
    push_frame(8'h17, 8'd2, 8'h00);
    run(5);
    check("r_busy_pre", busy, 1);
    rst = 1'b0;
    #1;
    check("r_busy", busy, 0);
    check("r_deq", rxq_deq, 0);
    check("r_outs", {word_valid, frame_type, frame_channel, err_code}, 0);
    run(2);
    rst = 1'b1;
    fifo.delete(); sync_pins();
    run(4);
    load_pl_a();
    push_frame(8'h17, 8'd2, 8'h00);
    run(30);
    check("r_nwords", n_words, 2);
    check("r_w1", words[1], 32'h55667788);
    check("r_done", n_done, 1);
    check("r_no_err", n_err, 0);
    check("r_starts", n_start, 2);

    check("deq_while_empty", viol_deq, 0);
    check("done_and_err", viol_both, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
